// File: rtl/nfc_host_cmd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : nfc_host_cmd_scheduler
//  Description : Host-side command stage of the NAND flash controller.
//                Buffers host commands in a FIFO and issues them in order on
//                the controller command valid/ready port. Each command waits
//                for its way's ready/busy line before it is presented. A
//                status-bearing command holds further issue until a status
//                beat returns or a timeout expires. Controller status is
//                forwarded to the host one cycle late.
//
//  Ports       : iSystemClock / iReset_n      clock, async active-low reset
//                iHost*                       host command + valid
//                oHostCMDReady                queue not full
//                o{Opcode..Length}, oCMDValid command to controller
//                iCMDReady                    controller accepts command
//                iReadyBusy                   per-way R/B, 1 = ready
//                iStatus / iStatusValid       controller status beat
//                oHostStatus / oHostStatusValid  registered status to host
//                oTimeout / oWayError         single-cycle event pulses
//                oQueueCount / oIdle          occupancy and idle flag
//
//  Revision    : 1.0  initial release
// ============================================================================
module nfc_host_cmd_scheduler #(
    parameter int NumberOfWays  = 2,
    parameter int WayBits       = 1,
    parameter int QueueDepth    = 4,
    parameter int TimeoutCycles = 1000000
) (
    input  logic                          iSystemClock,
    input  logic                          iReset_n,
    input  logic [5:0]                    iHostOpcode,
    input  logic [4:0]                    iHostTargetID,
    input  logic [4:0]                    iHostSourceID,
    input  logic [31:0]                   iHostAddress,
    input  logic [15:0]                   iHostLength,
    input  logic [WayBits-1:0]            iHostWay,
    input  logic                          iHostExpectStatus,
    input  logic                          iHostCMDValid,
    output logic                          oHostCMDReady,
    output logic [5:0]                    oOpcode,
    output logic [4:0]                    oTargetID,
    output logic [4:0]                    oSourceID,
    output logic [31:0]                   oAddress,
    output logic [15:0]                   oLength,
    output logic                          oCMDValid,
    input  logic                          iCMDReady,
    input  logic [NumberOfWays-1:0]       iReadyBusy,
    input  logic [23:0]                   iStatus,
    input  logic                          iStatusValid,
    output logic [23:0]                   oHostStatus,
    output logic                          oHostStatusValid,
    output logic                          oTimeout,
    output logic                          oWayError,
    output logic [$clog2(QueueDepth):0]   oQueueCount,
    output logic                          oIdle
);

    localparam int c_PTR_BITS   = $clog2(QueueDepth);
    localparam int c_COUNT_BITS = c_PTR_BITS + 1;
    localparam int c_TIMER_BITS = $clog2(TimeoutCycles);
    localparam int c_WAY_SLOTS  = 1 << WayBits;
    localparam int c_ENTRY_BITS = 1 + WayBits + 16 + 32 + 5 + 5 + 6;

    localparam logic [c_COUNT_BITS-1:0] c_FULL_COUNT  = c_COUNT_BITS'(QueueDepth);
    localparam logic [c_TIMER_BITS-1:0] c_TIMER_LIMIT = c_TIMER_BITS'(TimeoutCycles - 1);

    localparam logic [1:0] c_IDLE        = 2'd0;
    localparam logic [1:0] c_WAIT_WAY    = 2'd1;
    localparam logic [1:0] c_ISSUE       = 2'd2;
    localparam logic [1:0] c_WAIT_STATUS = 2'd3;

    // ------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------
    logic [c_ENTRY_BITS-1:0] r_queueMem [QueueDepth];
    logic [c_PTR_BITS-1:0]   r_wrPtr;
    logic [c_PTR_BITS-1:0]   r_rdPtr;
    logic [c_COUNT_BITS-1:0] r_count;

    logic [1:0]              r_state;
    logic                    w_push;
    logic                    w_pop;
    logic [c_ENTRY_BITS-1:0] w_pushEntry;
    logic [c_ENTRY_BITS-1:0] w_headEntry;

    logic [5:0]              w_headOpcode;
    logic [4:0]              w_headTargetId;
    logic [4:0]              w_headSourceId;
    logic [31:0]             w_headAddress;
    logic [15:0]             w_headLength;
    logic [WayBits-1:0]      w_headWay;
    logic                    w_headExpect;
    logic                    w_headWayValid;

    // Ready is derived from the registered count only, so a pop in the same
    // cycle never opens a slot for a push while full.
    assign oHostCMDReady = (r_count != c_FULL_COUNT);
    assign w_push        = iHostCMDValid && oHostCMDReady;
    assign w_pop         = (r_state == c_IDLE) && (r_count != '0);

    assign w_pushEntry = {iHostExpectStatus, iHostWay, iHostLength, iHostAddress,
                          iHostSourceID, iHostTargetID, iHostOpcode};
    assign w_headEntry = r_queueMem[r_rdPtr];
    assign {w_headExpect, w_headWay, w_headLength, w_headAddress,
            w_headSourceId, w_headTargetId, w_headOpcode} = w_headEntry;

    // Storage needs no reset: an entry is only read once count covers it.
    always_ff @(posedge iSystemClock) begin
        if (w_push) begin
            r_queueMem[r_wrPtr] <= w_pushEntry;
        end
    end

    // Pointers are c_PTR_BITS wide, so they wrap modulo the power-of-two depth.
    always_ff @(posedge iSystemClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A way index field wider than the number of ways can encode
    // non-existent ways; only then is a range check needed.
    generate
        if (c_WAY_SLOTS > NumberOfWays) begin : g_wayRangeCheck
            assign w_headWayValid = (int'(w_headWay) < NumberOfWays);
        end else begin : g_wayAlwaysValid
            assign w_headWayValid = 1'b1;
        end
    endgenerate

    // R/B padded to the full index range so any r_way value selects in range.
    logic [c_WAY_SLOTS-1:0] w_rbPadded;
    always_comb begin
        w_rbPadded                     = '0;
        w_rbPadded[NumberOfWays-1:0]   = iReadyBusy;
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    logic [5:0]              r_opcode;
    logic [4:0]              r_targetId;
    logic [4:0]              r_sourceId;
    logic [31:0]             r_address;
    logic [15:0]             r_length;
    logic [WayBits-1:0]      r_way;
    logic                    r_expect;
    logic                    r_cmdValid;
    logic [c_TIMER_BITS-1:0] r_timer;
    logic                    r_timeout;
    logic                    r_wayError;

    always_ff @(posedge iSystemClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state    <= c_IDLE;
            r_opcode   <= '0;
            r_targetId <= '0;
            r_sourceId <= '0;
            r_address  <= '0;
            r_length   <= '0;
            r_way      <= '0;
            r_expect   <= 1'b0;
            r_cmdValid <= 1'b0;
            r_timer    <= '0;
            r_timeout  <= 1'b0;
            r_wayError <= 1'b0;
        end else begin
            r_timeout  <= 1'b0;
            r_wayError <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_pop) begin
                        r_opcode   <= w_headOpcode;
                        r_targetId <= w_headTargetId;
                        r_sourceId <= w_headSourceId;
                        r_address  <= w_headAddress;
                        r_length   <= w_headLength;
                        r_way      <= w_headWay;
                        r_expect   <= w_headExpect;
                        // A command for a non-existent way is dropped here.
                        if (!w_headWayValid) begin
                            r_wayError <= 1'b1;
                        end else begin
                            r_state <= c_WAIT_WAY;
                        end
                    end
                end
                c_WAIT_WAY: begin
                    if (w_rbPadded[r_way]) begin
                        r_cmdValid <= 1'b1;
                        r_state    <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    if (iCMDReady) begin
                        r_cmdValid <= 1'b0;
                        if (r_expect) begin
                            r_timer <= '0;
                            r_state <= c_WAIT_STATUS;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end
                end
                c_WAIT_STATUS: begin
                    // A status beat on the limit cycle wins over the timeout.
                    if (iStatusValid) begin
                        r_state <= c_IDLE;
                    end else if (r_timer == c_TIMER_LIMIT) begin
                        r_timeout <= 1'b1;
                        r_state   <= c_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status forwarding: unconditional one-cycle delay, independent of FSM
    // ------------------------------------------------------------------
    logic [23:0] r_hostStatus;
    logic        r_hostStatusValid;

    always_ff @(posedge iSystemClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_hostStatus      <= '0;
            r_hostStatusValid <= 1'b0;
        end else begin
            r_hostStatus      <= iStatus;
            r_hostStatusValid <= iStatusValid;
        end
    end

    assign oOpcode          = r_opcode;
    assign oTargetID        = r_targetId;
    assign oSourceID        = r_sourceId;
    assign oAddress         = r_address;
    assign oLength          = r_length;
    assign oCMDValid        = r_cmdValid;
    assign oHostStatus      = r_hostStatus;
    assign oHostStatusValid = r_hostStatusValid;
    assign oTimeout         = r_timeout;
    assign oWayError        = r_wayError;
    assign oQueueCount      = r_count;
    assign oIdle            = (r_count == '0) && (r_state == c_IDLE);

endmodule
`default_nettype wire
